// File: rtl/conv_layer_sched.sv
`default_nettype none
// conv_layer_sched: layer/channel pass sequencer for the LeNet-5 data-correction stage.
// Optional build macro SCHED_TIMEOUT_EN adds a DRAIN watchdog (DRAIN_TIMEOUT cycles).
module conv_layer_sched #(
    parameter int PE_LATENCY    = 5,
    parameter int C1_CH         = 6,
    parameter int C2_CH         = 16
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int DRAIN_TIMEOUT = 4096
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dc_dout_start,
    input  logic       dc_empty,
    output logic [4:0] featmap_size,
    output logic       din_en,
    output logic [9:0] src_addr,
    output logic [1:0] layer_idx,
    output logic [4:0] ch_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    logic [10:0] feed_cnt;
    logic [9:0]  out_cnt;

    logic [4:0]  tbl_fmap;
    logic [9:0]  tbl_outs;
    logic [4:0]  tbl_ch_m1;
    logic [10:0] tbl_pix;
    logic [9:0]  tbl_pix_m1;
    logic [10:0] tbl_feed_m1;

    logic feed_last;
    logic drain_ok;
    logic last_ch;
    logic last_layer;
    logic wdog_hit;

    // Per-layer geometry: fmap side, expected output words, channel count.
    always_comb begin
        tbl_fmap  = 5'd30;
        tbl_outs  = 10'd784;
        tbl_ch_m1 = 5'(C1_CH - 1);
        case (layer_idx)
            2'd0: begin
                tbl_fmap  = 5'd30;
                tbl_outs  = 10'd784;
                tbl_ch_m1 = 5'(C1_CH - 1);
            end
            2'd1: begin
                tbl_fmap  = 5'd28;
                tbl_outs  = 10'd196;
                tbl_ch_m1 = 5'(C1_CH - 1);
            end
            2'd2: begin
                tbl_fmap  = 5'd14;
                tbl_outs  = 10'd144;
                tbl_ch_m1 = 5'(C2_CH - 1);
            end
            default: begin
                tbl_fmap  = 5'd12;
                tbl_outs  = 10'd36;
                tbl_ch_m1 = 5'(C2_CH - 1);
            end
        endcase
    end

    assign tbl_pix     = 11'(tbl_fmap) * 11'(tbl_fmap);
    assign tbl_pix_m1  = 10'(tbl_pix - 11'd1);
    assign tbl_feed_m1 = tbl_pix + 11'(PE_LATENCY) - 11'd1;

    assign feed_last  = (feed_cnt == tbl_feed_m1);
    // ">=" rather than "==" so an overrunning stage still lets the pass finish.
    assign drain_ok   = (out_cnt >= tbl_outs) && !dc_dout_start && dc_empty;
    assign last_ch    = (ch_idx == tbl_ch_m1);
    assign last_layer = (layer_idx == 2'd3);

`ifdef SCHED_TIMEOUT_EN
    logic [12:0] wdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= 13'd0;
        end else if (state != S_DRAIN || dc_dout_start || abort) begin
            wdog <= 13'd0;
        end else begin
            wdog <= wdog + 13'd1;
        end
    end

    assign wdog_hit = (state == S_DRAIN) && !dc_dout_start &&
                      (wdog == 13'(DRAIN_TIMEOUT - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CFG;
            S_CFG:   state_nx = S_FEED;
            S_FEED:  if (feed_last) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (drain_ok) begin
                    state_nx = S_NEXT;
                end else if (wdog_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_NEXT:  state_nx = (last_ch && last_layer) ? S_DONE : S_CFG;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign din_en = (state == S_FEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            featmap_size <= 5'd30;
            src_addr     <= 10'd0;
            layer_idx    <= 2'd0;
            ch_idx       <= 5'd0;
            feed_cnt     <= 11'd0;
            out_cnt      <= 10'd0;
            err          <= 1'b0;
        end else if (abort) begin
            // featmap_size and err deliberately hold across an abort.
            src_addr  <= 10'd0;
            layer_idx <= 2'd0;
            ch_idx    <= 5'd0;
            feed_cnt  <= 11'd0;
            out_cnt   <= 10'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    layer_idx <= 2'd0;
                    ch_idx    <= 5'd0;
                    feed_cnt  <= 11'd0;
                    out_cnt   <= 10'd0;
                    src_addr  <= 10'd0;
                    if (start) begin
                        err <= 1'b0;
                    end
                end
                S_CFG: begin
                    featmap_size <= tbl_fmap;
                end
                S_FEED: begin
                    feed_cnt <= feed_cnt + 11'd1;
                    if (src_addr != tbl_pix_m1) begin
                        src_addr <= src_addr + 10'd1;
                    end
                    if (dc_dout_start) begin
                        out_cnt <= out_cnt + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (dc_dout_start) begin
                        out_cnt <= out_cnt + 10'd1;
                    end
                    if (drain_ok && (out_cnt > tbl_outs)) begin
                        err <= 1'b1;
                    end else if (!drain_ok && wdog_hit) begin
                        err <= 1'b1;
                    end
                end
                S_NEXT: begin
                    feed_cnt <= 11'd0;
                    out_cnt  <= 10'd0;
                    src_addr <= 10'd0;
                    if (last_ch) begin
                        ch_idx <= 5'd0;
                        if (!last_layer) begin
                            layer_idx <= layer_idx + 2'd1;
                        end
                    end else begin
                        ch_idx <= ch_idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// tb_conv_layer_sched: randomized bench with a pass-level reference model and stage model.
module tb_conv_layer_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dc_dout_start = 1'b0;
    logic       dc_empty = 1'b1;
    logic [4:0] featmap_size;
    logic       din_en;
    logic [9:0] src_addr;
    logic [1:0] layer_idx;
    logic [4:0] ch_idx;
    logic       busy;
    logic       done;
    logic       err;

    conv_layer_sched dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .dc_dout_start (dc_dout_start),
        .dc_empty      (dc_empty),
        .featmap_size  (featmap_size),
        .din_en        (din_en),
        .src_addr      (src_addr),
        .layer_idx     (layer_idx),
        .ch_idx        (ch_idx),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    function automatic int ref_fmap(input int l);
        case (l)
            0: return 30;
            1: return 28;
            2: return 14;
            default: return 12;
        endcase
    endfunction

    function automatic int ref_outs(input int l);
        case (l)
            0: return 784;
            1: return 196;
            2: return 144;
            default: return 36;
        endcase
    endfunction

    function automatic int ref_ch(input int l);
        return (l < 2) ? 6 : 16;
    endfunction

    typedef struct {
        int l;
        int c;
    } pass_t;

    pass_t exp_q[$];

    task automatic push_pass(input int l, input int c);
        pass_t p;
        p.l = l;
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic load_run();
        exp_q.delete();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < ref_ch(l); c++)
                push_pass(l, c);
    endtask

    // Knobs set by the sequence, read by the monitor/stage model.
    int expect_cut  = 0;
    int stage_mute  = 0;
    int stage_extra = 0;

    // Monitor results.
    int pass_cnt      = 0;
    int done_cnt      = 0;
    int first_len     = 0;
    int first_max_src = 0;
    int second_ch     = -1;

    // Monitor + stage model, evaluated on the falling edge.
    initial begin : monitor
        int    prev_din;
        int    burst_len;
        int    pix;
        int    pend;
        int    dly;
        int    gaps;
        pass_t p;
        prev_din = 0; burst_len = 0; pix = 1; pend = 0; dly = 0; gaps = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_din = 0; pend = 0; dly = 0;
                dc_dout_start = 1'b0;
                dc_empty      = 1'b1;
                continue;
            end
            if (done) begin
                done_cnt++;
                chk("busy_with_done", busy, 1);
            end
            if (din_en) chk("busy_in_feed", busy, 1);
            if (din_en && !prev_din) begin
                pass_cnt++;
                chk("pass_available", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("pass_layer", layer_idx, p.l);
                    chk("pass_ch", ch_idx, p.c);
                    chk("pass_fmap", featmap_size, ref_fmap(p.l));
                    pix = ref_fmap(p.l) * ref_fmap(p.l);
                    pend = stage_mute ? 0 : ref_outs(p.l) + stage_extra;
                    if (p.l == 0 && p.c == 0) begin
                        dly  = 66;
                        gaps = 0;
                    end else begin
                        dly  = $urandom_range(5, 120);
                        gaps = 1;
                    end
                end
                if (pass_cnt == 2) second_ch = ch_idx;
                burst_len = 0;
            end
            if (din_en) begin
                chk("src_addr", src_addr, (burst_len < pix) ? burst_len : pix - 1);
                if (pass_cnt == 1 && src_addr > first_max_src) first_max_src = src_addr;
                burst_len++;
            end
            if (!din_en && prev_din) begin
                if (expect_cut == 0) chk("burst_len", burst_len, pix + 5);
                if (pass_cnt == 1) first_len = burst_len;
            end
            prev_din = din_en;
            if (!busy && !din_en) begin
                pend = 0;
                dly  = 0;
            end
            if (dly > 0) begin
                dly--;
                dc_dout_start = 1'b0;
            end else if (pend > 0) begin
                dc_dout_start = gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
                if (dc_dout_start) pend--;
            end else begin
                dc_dout_start = 1'b0;
            end
            dc_empty = (pend == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : global_bound
        #900000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin : sequence_main
        int n;
        int sent;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_fmap", featmap_size, 30);
        chk("rst_din_en", din_en, 0);
        chk("rst_src", src_addr, 0);
        chk("rst_layer", layer_idx, 0);
        chk("rst_ch", ch_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Full 44-pass run with random stage timing and stray starts.
        load_run();
        pass_cnt = 0; done_cnt = 0; expect_cut = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_din_en", din_en, 0);
        tick();
        chk("first_din_en", din_en, 1);
        n = 0; sent = 0;
        while (done_cnt == 0 && n < 40000) begin
            if (!sent && layer_idx == 2 && din_en) begin
                start = 1'b1;
                sent  = 1;
            end else begin
                start = busy && ($urandom_range(0, 499) == 0);
            end
            tick();
            start = 1'b0;
            n++;
        end
        chk("run_done_count", done_cnt, 1);
        chk("run_busy_after_done", busy, 0);
        chk("run_done_width", done, 0);
        chk("run_err", err, 0);
        chk("run_passes", pass_cnt, 44);
        chk("run_queue_left", exp_q.size(), 0);
        chk("first_burst_len", first_len, 905);
        chk("first_max_src", first_max_src, 899);
        chk("second_pass_ch", second_ch, 1);
        repeat (3) tick();
        chk("no_extra_done", done_cnt, 1);

        // abort beats start in the same idle cycle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", busy, 0);
        tick();
        chk("still_idle", busy, 0);

        // abort at FEED cycle 100.
        exp_q.delete();
        push_pass(0, 0);
        pass_cnt = 0; expect_cut = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (100) tick();
        chk("feed_cycle100_src", src_addr, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_din_en", din_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_src", src_addr, 0);
        chk("abort_fmap_hold", featmap_size, 30);
        tick();
        expect_cut = 0;

        // Restart at 0/0; first pass overruns by one word.
        exp_q.delete();
        push_pass(0, 0);
        push_pass(0, 1);
        pass_cnt = 0; stage_extra = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (pass_cnt < 1 && n < 100) begin tick(); n++; end
        stage_extra = 0;
        n = 0;
        while (pass_cnt < 2 && n < 3000) begin tick(); n++; end
        chk("overrun_next_pass", pass_cnt, 2);
        chk("overrun_err", err, 1);
        expect_cut = 1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("err_sticky_idle", err, 1);
        expect_cut = 0;

        // rst during layer-1 DRAIN (stage holds its output back).
        load_run();
        pass_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared_by_start", err, 0);
        n = 0;
        while (layer_idx != 1 && n < 10000) begin tick(); n++; end
        stage_mute = 1;
        n = 0;
        while (!(pass_cnt == 7 && !din_en) && n < 3000) begin tick(); n++; end
        chk("reached_l1_drain", pass_cnt, 7);
        repeat (50) tick();
        chk("drain_waits_busy", busy, 1);
        chk("drain_layer", layer_idx, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_fmap", featmap_size, 30);
        chk("async_rst_din_en", din_en, 0);
        chk("async_rst_layer", layer_idx, 0);
        chk("async_rst_ch", ch_idx, 0);
        chk("async_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Stage never answers: watchdog or indefinite wait.
        exp_q.delete();
        push_pass(0, 0);
        pass_cnt = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pass_cnt >= 1 && !din_en) && n < 2000) begin tick(); n++; end
        chk("mute_drain_entry", pass_cnt, 1);
`ifdef SCHED_TIMEOUT_EN
        n = 0;
        while (!done && n < 5000) begin tick(); n++; end
        chk("wdog_latency", n, 4096);
        chk("wdog_err", err, 1);
        tick();
        chk("wdog_idle", busy, 0);
`else
        repeat (5000) tick();
        chk("no_wdog_busy", busy, 1);
        chk("no_wdog_done", done_cnt, 0);
        chk("no_wdog_err", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        stage_mute = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
